inst_prefetch: RTL

INST_PREFETCH -- requirements
Module: inst_prefetch

---
 rtl/inst_prefetch.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/inst_prefetch.sv
// Sequential instruction prefetcher: runs ahead of the controller's PC into a small FIFO
// and redirects on branches. Optional hit/miss statistics are built with PREFETCH_STATS_EN.
//
// state | meaning
// IDLE  | no memory request outstanding
// BUSY  | one request outstanding, its data will be pushed into the FIFO
// DROP  | one request outstanding, its data will be discarded (stale after a redirect)
module inst_prefetch #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_pc,
    input  logic        cpu_fetch,
    output logic [15:0] cpu_inst,
    output logic        cpu_valid,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state;
    logic [15:0]   fifo_addr [DEPTH];
    logic [15:0]   fifo_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [15:0]   pf_addr;

    logic [15:0]   head_addr;
    logic [15:0]   head_data;
    logic [15:0]   e_addr;
    logic          hit;
    logic          miss;
    logic          push;

    assign head_addr = fifo_addr[rd_ptr];
    assign head_data = fifo_data[rd_ptr];

    // Address the controller should be asking for if no redirect happened.
    always_comb begin
        e_addr = pf_addr;
        if (count != '0)
            e_addr = head_addr;
        else if (state == BUSY)
            e_addr = mem_addr;
    end

    assign hit  = (count != '0) && cpu_fetch && (head_addr == cpu_pc);
    assign miss = cpu_fetch && (e_addr != cpu_pc);
    assign push = (state == BUSY) && mem_ack && !miss;

    assign cpu_valid = hit && !rst;
    assign cpu_inst  = cpu_valid ? head_data : 16'h0000;

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_addr[wr_ptr] <= mem_addr;
            fifo_data[wr_ptr] <= mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            pf_addr  <= 16'h0000;
            mem_req  <= 1'b0;
            mem_addr <= 16'h0000;
        end else if (miss) begin
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            pf_addr <= cpu_pc;
            case (state)
                BUSY, DROP: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end else begin
                        state <= DROP;
                    end
                end
                default: state <= IDLE;
            endcase
        end else begin
            if (hit)
                rd_ptr <= rd_ptr + PW'(1);
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            case ({push, hit})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (count < CW'(DEPTH)) begin
                        mem_req  <= 1'b1;
                        mem_addr <= pf_addr;
                        pf_addr  <= pf_addr + 16'd1;
                        state    <= BUSY;
                    end
                end
                BUSY, DROP: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PREFETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= 16'h0000;
            miss_cnt <= 16'h0000;
        end else begin
            if (hit && hit_cnt != 16'hFFFF)
                hit_cnt <= hit_cnt + 16'd1;
            if (miss && miss_cnt != 16'hFFFF)
                miss_cnt <= miss_cnt + 16'd1;
        end
    end
`else
    assign hit_cnt  = 16'h0000;
    assign miss_cnt = 16'h0000;
`endif

endmodule
